instruction_fetch: RTL

- Front-end stage directly upstream of the instruction decoder.
- Owns the program counter and issues in-order word reads to instruction memory.
- Buffers returned words with their PC in a small FIFO and presents them to the decoder over a valid/ready handshake.
- Accepts branch/jump redirects from execute, flushes wrong-path instructions and discards their responses still in flight.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/instruction_fetch.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic {
        FETCH_RUN,
        FETCH_DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Masking keeps every address bit in use, so the low bits are cleared rather than dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between memory responses and the decoder.
// Supports synchronous flush and simultaneous push/pop; count feeds the request credit check.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];
    assign count   = count_q;

    // Flush shares the reset path: pointers and count go back to zero, any same-cycle push or pop is lost.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues credit-limited word reads and buffers instructions for the decoder.
// Define FETCH_PERF_CNT_EN to add the perf_fetched / perf_flushed / perf_stall counters.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed,
    output logic [31:0] perf_stall
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e   state_q;
    fetch_state_e   state_d;
    logic [31:0]    req_pc_q;
    logic [31:0]    req_pc_d;
    logic [31:0]    resp_pc_q;
    logic [31:0]    resp_pc_d;
    logic [CNT_W-1:0] outstanding_q;
    logic [CNT_W-1:0] outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q;
    logic [CNT_W-1:0] drop_cnt_d;

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    fetch_entry_t     fifo_head;
    fetch_entry_t     push_entry;

    logic [CNT_W:0]   credit_used;
    logic             credit_ok;
    logic             req_fire;
    logic             resp_fire;
    logic             resp_keep;
    logic             resp_drop;

    // Every request holds a FIFO slot until its instruction is consumed, so the buffer can never overflow.
    assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign credit_ok   = credit_used < (CNT_W+1)'(FIFO_DEPTH);

    assign imem_req_valid = !reset && (state_q == FETCH_RUN) && credit_ok;
    assign imem_req_addr  = req_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign resp_fire = imem_resp_valid && !reset;
    assign resp_drop = resp_fire && (drop_cnt_q != '0);
    assign resp_keep = resp_fire && (drop_cnt_q == '0);

    assign push_entry.data = imem_resp_data;
    assign push_entry.pc   = resp_pc_q;
    assign fifo_push       = resp_keep && !redirect_valid;
    assign fifo_pop        = instr_valid && instr_ready && !redirect_valid;

    assign instr_valid = !fifo_empty;
    assign instr       = fifo_head.data;
    assign instr_pc    = fifo_head.pc;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // A redirect overrides everything: both PCs retarget and every response still owed becomes a drop.
    always_comb begin
        state_d       = state_q;
        req_pc_d      = req_pc_q;
        resp_pc_d     = resp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(resp_fire);

        if (req_fire) begin
            req_pc_d = req_pc_q + PC_STEP;
        end
        if (resp_keep) begin
            resp_pc_d = resp_pc_q + PC_STEP;
        end
        if (resp_drop) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end

        if (redirect_valid) begin
            req_pc_d   = word_align(redirect_pc);
            resp_pc_d  = word_align(redirect_pc);
            drop_cnt_d = outstanding_d;
            state_d    = (outstanding_d != '0) ? FETCH_DRAIN : FETCH_RUN;
        end else begin
            case (state_q)
                FETCH_RUN:   state_d = FETCH_RUN;
                FETCH_DRAIN: state_d = (drop_cnt_d == '0) ? FETCH_RUN : FETCH_DRAIN;
                default:     state_d = FETCH_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH_RUN;
            req_pc_q      <= word_align(RESET_PC);
            resp_pc_q     <= word_align(RESET_PC);
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            req_pc_q      <= req_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] flushed_inc;

    // Flushed work: responses dropped while draining, buffered entries and a push lost to a redirect.
    always_comb begin
        flushed_inc = 32'(resp_drop);
        if (redirect_valid) begin
            flushed_inc = flushed_inc + 32'(fifo_count) + 32'(resp_keep);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
            perf_stall   <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(instr_valid && instr_ready);
            perf_flushed <= perf_flushed + flushed_inc;
            perf_stall   <= perf_stall + 32'(instr_valid && !instr_ready);
        end
    end
`endif

endmodule
